// File: rtl/axil_pkg.sv
// Shared AXI4-Lite write-side definitions: response codes, FSM encoding, lane geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BYTE_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } wr_state_t;

  // An address hits the bank only when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int idx_w);
    return ((addr >> (idx_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each set strobe bit takes that byte from new_word, else keeps old_word.
// Latency: combinational.
// Backpressure: none.
module axil_strb_merge
  import axil_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged
);

  // Start from the old contents and overwrite only the enabled lanes.
  always_comb begin
    merged = old_word;
    for (int n = 0; n < STRB_W; n++) begin
      if (strb[n]) begin
        merged[n*BYTE_W +: BYTE_W] = new_word[n*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/axil_slave_write_ctrl.sv
// AXI4-Lite write slave: joins AW and W, applies WSTRB to a register bank, returns B.
// Latency: AW+W on edge t -> register and BVALID updated on edge t+1; min 3 cycles per write.
// Backpressure: one transaction outstanding; readies drop from WRITE until the B handshake.
module axil_slave_write_ctrl
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [31:0]      AWADDR,
  input  logic             WVALID,
  output logic             WREADY,
  input  logic [31:0]      WDATA,
  input  logic [3:0]       WSTRB,
  output logic             BVALID,
  input  logic             BREADY,
  output logic [1:0]       BRESP,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic             wr_pulse,
  output logic [IDX_W-1:0] wr_idx
);

  wr_state_t          state;
  logic [IDX_W-1:0]   hold_idx;
  logic               hold_oor;
  logic [DATA_W-1:0]  hold_data;
  logic [STRB_W-1:0]  hold_strb;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  merged_word;
  logic               aw_hs;
  logic               w_hs;
  logic [IDX_W-1:0]   aw_idx;
  logic               aw_oor;

  // Readies come from state alone; ARESETn (active-high) forces them low.
  assign AWREADY = !ARESETn && ((state == IDLE) || (state == WAIT_AW));
  assign WREADY  = !ARESETn && ((state == IDLE) || (state == WAIT_W));

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign aw_idx = AWADDR[IDX_W+1:2];
  assign aw_oor = !addr_in_range(AWADDR, IDX_W);

  // Read port is a plain mux, so it shows the new value from the cycle after commit.
  assign rd_data = regs[rd_idx];

  axil_strb_merge u_merge (
    .old_word (regs[hold_idx]),
    .new_word (hold_data),
    .strb     (hold_strb),
    .merged   (merged_word)
  );

  // Write FSM: captures AW/W in either order, then issues B and the notify pulse.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state     <= IDLE;
      hold_idx  <= '0;
      hold_oor  <= 1'b0;
      hold_data <= '0;
      hold_strb <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      wr_pulse  <= 1'b0;
      wr_idx    <= '0;
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            hold_idx <= aw_idx;
            hold_oor <= aw_oor;
          end
          if (w_hs) begin
            hold_data <= WDATA;
            hold_strb <= WSTRB;
          end
          if (aw_hs && w_hs) begin
            state <= WRITE;
          end else if (aw_hs) begin
            state <= WAIT_W;
          end else if (w_hs) begin
            state <= WAIT_AW;
          end
        end
        WAIT_W: begin
          if (w_hs) begin
            hold_data <= WDATA;
            hold_strb <= WSTRB;
            state     <= WRITE;
          end
        end
        WAIT_AW: begin
          if (aw_hs) begin
            hold_idx <= aw_idx;
            hold_oor <= aw_oor;
            state    <= WRITE;
          end
        end
        WRITE: begin
          BVALID   <= 1'b1;
          BRESP    <= hold_oor ? RESP_SLVERR : RESP_OKAY;
          wr_pulse <= !hold_oor;
          wr_idx   <= hold_idx;
          state    <= RESP;
        end
        RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register bank: only the held index is touched, and only on the WRITE exit edge.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == WRITE) && !hold_oor) begin
      regs[hold_idx] <= merged_word;
    end
  end

endmodule

// File: doc/axil_slave_write_ctrl.md
Name: axil_slave_write_ctrl

Overview:
- AXI4-Lite slave write-side controller, directly downstream of the write-data master/slave channel stage.
- Joins the write-address (AW) and write-data (W) channels and applies WSTRB byte enables to a local register bank.
- Returns the write response (B) to the master.
- Provides a combinational read port and a write-notify pulse for the register consumers.

Parameters:
- NUM_REGS, 16, number of 32-bit registers in the bank (power of two, 2..256).
- IDX_W, 4, register index width; must equal log2(NUM_REGS).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-high (logic 1 = reset asserted).
- AWVALID  in  1  write-address valid.
- AWREADY  out  1  write-address ready.
- AWADDR  in  32  byte address.
- WVALID  in  1  write-data valid.
- WREADY  out  1  write-data ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit n covers WDATA[8n+7:8n].
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- rd_idx  in  IDX_W  register read index.
- rd_data  out  32  combinational read of reg[rd_idx].
- wr_pulse  out  1  one-cycle pulse on a committed in-range write.
- wr_idx  out  IDX_W  index written; valid while wr_pulse=1.

Behaviour:
- Reset is ARESETn, asynchronous, active-high; clock is ACLK.
- While reset is asserted:
  - state = IDLE; all registers = 0; holding registers and flags cleared.
  - BVALID=0, BRESP=00, wr_pulse=0, wr_idx=0.
  - AWREADY and WREADY forced to 0.
- Reset asserted mid-transaction discards any pending AW/W/B; nothing is written.
- States:
  - IDLE: AWREADY=1, WREADY=1.
    - AW and W handshakes on the same edge -> WRITE.
    - AW only -> WAIT_W (address latched).
    - W only -> WAIT_AW (data and strobe latched).
  - WAIT_W: AWREADY=0, WREADY=1. W handshake -> WRITE.
  - WAIT_AW: AWREADY=1, WREADY=0. AW handshake -> WRITE.
  - WRITE: both readies 0; single cycle.
    - In range: on the exiting edge, reg[idx] byte n <= held WDATA byte n for each held WSTRB[n]=1; other bytes unchanged.
    - Same edge: BVALID<=1, BRESP set, wr_pulse<=1 if in range. Next state RESP.
  - RESP: both readies 0. BVALID holds and BRESP is stable until BREADY=1. The BVALID&&BREADY edge -> IDLE, BVALID<=0.
- Handshake = VALID&&READY sampled at the ACLK rising edge.
- Readies are combinational from state (and the reset force). They do not depend on VALID.
- Latency: AW+W together at edge t -> register updated and BVALID=1 after edge t+1. With BREADY already high, BVALID drops after edge t+2. Minimum 3 cycles per write, one outstanding transaction max.
- Address decode:
  - idx = AWADDR[IDX_W+1:2]; AWADDR[1:0] ignored.
  - Out of range when AWADDR[31:IDX_W+2] != 0: no register change, wr_pulse=0, BRESP=10.
  - Otherwise BRESP=00.
- WSTRB=0000, in range: no bytes change, BRESP=00, wr_pulse still pulses.
- wr_pulse high exactly one cycle, the cycle following the WRITE commit edge. wr_idx is registered with it.
- rd_data reflects register contents after the commit edge. Reading the index being written shows the old value during WRITE and the new value from the next cycle.
- VALID held without READY is simply waited on; no timeout.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - write-FSM state encoding (IDLE, WAIT_W, WAIT_AW, WRITE, RESP).
  - byte-lane width constant 8.
- One natural sub-module: axil_strb_merge, combinational. Inputs old word, new word, strobe; output merged word. Instantiated once for the selected register.

Test Plan:
- Reset: ARESETn=1 for 3 cycles -> AWREADY=WREADY=BVALID=0, rd_data=0 for all idx. Release -> AWREADY=WREADY=1 in IDLE.
- AW 0x08 and W 0xDEADBEEF/1111 on the same edge, BREADY=1:
  - reg[2]=0xDEADBEEF after edge t+1; BVALID high one cycle, BRESP=00.
  - wr_pulse=1 with wr_idx=2.
- Partial strobe: reg[3]=0x11223344, write 0xAABBCCDD with WSTRB=0101 -> reg[3]=0x11BB33DD, BRESP=00.
- W before AW: W 0x12345678/1111 at t, AW 0x04 at t+3 -> state WAIT_AW with WREADY=0 in between; reg[1]=0x12345678; no double write.
- Out of range: AW 0x40 (NUM_REGS=16), W 0xFFFFFFFF -> BRESP=10, wr_pulse=0, all registers unchanged.
- Backpressure plus reset: BREADY=0 for 5 cycles -> BVALID and BRESP stable, readies 0. Assert ARESETn during RESP -> BVALID=0 immediately (async), registers=0, IDLE after release.
